// File: rtl/demux_pkg.sv
// Shared sizing for the 1-to-8 stream demultiplexer and its lane registers.
package demux_pkg;

    localparam int WIDTH   = 8;   // default lane data width
    localparam int N_LANES = 8;   // number of output lanes
    localparam int SEL_W   = 3;   // width of the lane select
    localparam int CNT_W   = 16;  // width of the accepted-word counter

endpackage

// File: rtl/demux_lane.sv
// One-entry output lane register: a valid bit plus one data word.
// A load always wins over a drain, so a same-cycle drain+load keeps the
// lane full with the new word (one word per cycle per lane).
module demux_lane
    import demux_pkg::*;
#(
    parameter int DW = WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          drain,
    output logic          valid,
    output logic [DW-1:0] data
);

    // Lane state: reset clears, load fills/replaces, drain empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_8x8.sv
// Routes each accepted input word into one of eight one-entry lane
// registers selected by in_sel, and counts accepted words.
//
// Handshake: a word moves on a port in any cycle where its valid and ready
// are both high at the rising edge. valid may not depend on ready; once
// in_valid is raised, in_valid/in_data/in_sel hold until accepted. The
// input side is ready when the selected lane is empty or is being drained
// in the same cycle; outputs come straight from the lane registers.
module stream_demux_8x8
    import demux_pkg::*;
#(
    parameter int WIDTH = demux_pkg::WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [SEL_W-1:0]           in_sel,
    output logic [N_LANES-1:0]         out_valid,
    input  logic [N_LANES-1:0]         out_ready,
    output logic [N_LANES*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]           xfer_count
);

    logic               accept;
    logic [N_LANES-1:0] lane_valid;

    // Ready when the target lane is free now or frees up at this edge.
    always_comb begin
        in_ready = !rst && (!lane_valid[in_sel] || out_ready[in_sel]);
        accept   = in_valid && in_ready;
    end

    assign out_valid = lane_valid;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        demux_lane #(
            .DW (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (accept && (in_sel == SEL_W'(i))),
            .load_data (in_data),
            .drain     (lane_valid[i] && out_ready[i]),
            .valid     (lane_valid[i]),
            .data      (out_data[i*WIDTH +: WIDTH])
        );
    end

    // Accepted-word counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count <= '0;
        end else if (accept) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_demux_8x8.sv
// Directed self-checking bench for stream_demux_8x8.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_stream_demux_8x8;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [2:0]     in_sel;
    logic [7:0]     out_valid;
    logic [7:0]     out_ready;
    logic [8*W-1:0] out_data;
    logic [15:0]    xfer_count;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    stream_demux_8x8 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input int i);
        return out_data[i*W +: W];
    endfunction

    // Advance one full cycle: through the rising edge to the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] sel, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        int ready_drops;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;

        // Reset
        tick();
        tick();
        offer(3'd2, 8'h77);
        check("ready_in_reset", in_ready, 1'b0);
        idle();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 8'h00);
        check("rst_out_data", out_data[31:0], 32'h0);
        check("rst_xfer", xfer_count, 16'd0);

        // First word to lane 5
        offer(3'd5, 8'hA5);
        check("first_ready", in_ready, 1'b1);
        tick();
        idle();
        check("first_valid", out_valid, 8'b0010_0000);
        check("first_data", lane(5), 8'hA5);
        check("first_xfer", xfer_count, 16'd1);

        // Idle input with junk sel/data changes nothing
        in_sel  = 3'd1;
        in_data = 8'hEE;
        tick();
        check("idle_valid", out_valid, 8'b0010_0000);
        check("idle_xfer", xfer_count, 16'd1);

        // Lane 5 full and stalled: new word must wait
        offer(3'd5, 8'h5A);
        check("stall_ready", in_ready, 1'b0);
        tick();
        check("stall_hold_data", lane(5), 8'hA5);
        check("stall_xfer", xfer_count, 16'd1);
        out_ready[5] = 1'b1;
        #1;
        check("drain_ready", in_ready, 1'b1);
        tick();
        out_ready = '0;
        idle();
        check("replace_valid", out_valid, 8'b0010_0000);
        check("replace_data", lane(5), 8'h5A);
        check("replace_xfer", xfer_count, 16'd2);

        // Lanes 2/3 stalled full, lane 6 still accepts
        offer(3'd2, 8'hC2);
        tick();
        offer(3'd3, 8'hC3);
        tick();
        offer(3'd6, 8'h66);
        check("other_lane_ready", in_ready, 1'b1);
        tick();
        idle();
        check("other_lane_valid", out_valid, 8'b0110_1100);
        check("lane2_unchanged", lane(2), 8'hC2);
        check("lane3_unchanged", lane(3), 8'hC3);
        check("lane6_data", lane(6), 8'h66);
        check("other_lane_xfer", xfer_count, 16'd5);

        // Drain everything
        out_ready = 8'hFF;
        tick();
        check("drained_valid", out_valid, 8'h00);

        // Back-to-back words 0..7 to lanes 0..7 with all sinks ready
        for (int i = 0; i < 8; i++) begin
            offer(3'(i), W'(i));
            check($sformatf("b2b_ready_%0d", i), in_ready, 1'b1);
            exp_q.push_back(W'(i));
            tick();
            check($sformatf("b2b_valid_%0d", i), out_valid, 32'(8'h01 << i));
            if (exp_q.size() != 0)
                check($sformatf("b2b_data_%0d", i), lane(i), exp_q.pop_front());
        end
        idle();
        tick();
        check("b2b_all_drained", out_valid, 8'h00);
        check("b2b_xfer", xfer_count, 16'd13);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Lanes 0 and 4 full, then reset with a word offered
        out_ready = '0;
        offer(3'd0, 8'h10);
        tick();
        offer(3'd4, 8'h14);
        tick();
        check("pre_rst_valid", out_valid, 8'b0001_0001);
        rst = 1'b1;
        offer(3'd1, 8'h11);
        check("rst_blocks_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        idle();
        check("post_rst_valid", out_valid, 8'h00);
        check("post_rst_xfer", xfer_count, 16'd0);
        check("post_rst_lane0", lane(0), 8'h00);
        check("post_rst_lane4", lane(4), 8'h00);
        offer(3'd1, 8'h11);
        check("post_rst_ready", in_ready, 1'b1);
        tick();
        idle();
        check("post_rst_accept_valid", out_valid, 8'b0000_0010);
        check("post_rst_accept_data", lane(1), 8'h11);
        check("post_rst_accept_xfer", xfer_count, 16'd1);

        // Counter wrap: bring count to 65535, then one more accept
        out_ready   = 8'hFF;
        ready_drops = 0;
        for (int n = 0; n < 65534; n++) begin
            offer(3'd7, W'(n));
            if (in_ready !== 1'b1) ready_drops++;
            tick();
        end
        check("bulk_ready_drops", ready_drops, 0);
        check("xfer_at_max", xfer_count, 16'hFFFF);
        offer(3'd7, 8'hAB);
        tick();
        idle();
        check("xfer_wrap", xfer_count, 16'h0000);
        check("wrap_word", lane(7), 8'hAB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
